fft_frame_ctrl: RTL and testbench

- Frame sequencer that sits between the AD sample path (offset-removed, sign-extended samples) and the streaming FFT core.
- Cuts the continuous sample stream into FFT_LEN-point frames and drives the core's sink handshake (sink_valid/sink_sop/sink_eop/sink_real) while honouring sink_ready.
- Tracks the output frame: bin index, frame-done pulse, framing errors.
- Supports one-shot burst capture (start pulse) and free-running continuous mode.

---
 rtl/fft_ctrl_pkg.sv | 19 +
 rtl/fft_bin_tracker.sv | 99 +++++++++
 rtl/fft_frame_ctrl.sv | 147 ++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg
// Shared definitions for the FFT frame sequencer slice: the sequencer state
// encoding and the default frame geometry used by fft_frame_ctrl and
// fft_bin_tracker.
package fft_ctrl_pkg;

  // Default frame geometry: 1024-point frames of 12-bit signed samples.
  localparam int FFT_LEN_DEF = 1024;
  localparam int CNT_W_DEF   = 10;
  localparam int DATA_W_DEF  = 12;

  // Sequencer states. The encoding is fixed so it can be probed in the lab.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_OUT = 2'd2
  } state_t;

endpackage

// File: rtl/fft_bin_tracker.sv
// fft_bin_tracker
// Follows the FFT core's output stream. It reports the index of the bin
// currently on the bus, pulses frame_done after each completed frame, and
// latches framing violations.
//
// Optional build macro: FFT_FRAME_CNT_EN adds a 16-bit wrapping frame counter.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   source_valid  FFT output valid
//   source_sop    FFT output first bin
//   source_eop    FFT output last bin
//   bin_idx       index of the bin on the bus (meaningful while source_valid)
//   frame_done    one-cycle pulse, one cycle after an accepted source_eop
//   frm_err       sticky framing violation flag
//   frame_cnt     (FFT_FRAME_CNT_EN only) count of frame_done pulses
module fft_bin_tracker
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             source_valid,
  input  logic             source_sop,
  input  logic             source_eop,
  output logic [CNT_W-1:0] bin_idx,
  output logic             frame_done,
  output logic             frm_err
`ifdef FFT_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FFT_LEN - 1);

  logic [CNT_W-1:0] last_bin;
  logic [CNT_W-1:0] cur_bin;
  logic             frame_open;
  logic             violation;

  // The bus carries a new bin every valid cycle. We therefore derive the
  // current index from the previous bin so that bin_idx lines up with the
  // data, instead of trailing it by one cycle. The index saturates at the
  // last bin.
  always_comb begin
    cur_bin = last_bin;
    if (source_sop) begin
      cur_bin = '0;
    end else if (last_bin != LAST_BIN) begin
      cur_bin = last_bin + 1'b1;
    end
  end

  assign bin_idx = source_valid ? cur_bin : last_bin;

  // A sop is legal only after a complete frame or when no frame is open.
  // An eop must land on the last bin. Data without a sop needs an open frame.
  assign violation = source_valid &
                     ((source_sop & frame_open & (last_bin != LAST_BIN)) |
                      (source_eop & (cur_bin != LAST_BIN)) |
                      (~source_sop & ~frame_open));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_bin   <= '0;
      frame_open <= 1'b0;
      frame_done <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      frame_done <= source_valid & source_eop;
      if (violation) begin
        frm_err <= 1'b1;
      end
      if (source_valid) begin
        last_bin <= cur_bin;
        if (source_eop) begin
          frame_open <= 1'b0;
        end else if (source_sop) begin
          frame_open <= 1'b1;
        end
      end
    end
  end

`ifdef FFT_FRAME_CNT_EN
  // Count completed output frames; the counter wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Sits between the AD sample path and a streaming FFT core. It cuts the
// sample stream into FFT_LEN-point frames and drives the core's sink
// handshake through a one-entry output register. It also tracks the output
// frames through fft_bin_tracker. A start pulse captures one frame;
// cont_en keeps capturing frame after frame.
//
// Optional build macro: FFT_FRAME_CNT_EN adds the frame_cnt output.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start                        arms one frame (only honoured in IDLE / at WAIT_OUT end)
//   cont_en                      continuous mode, sampled at each frame boundary
//   smp_valid, smp_data          incoming samples
//   sink_ready                   FFT core accepts data
//   sink_valid/sop/eop/real      registered sink handshake to the core
//   source_valid/sop/eop         FFT output stream framing
//   bin_idx, frame_done, frm_err output-side tracking
//   busy                         state is not IDLE
//   ovf_err                      sticky; a sample was dropped under backpressure
//   frame_cnt                    (FFT_FRAME_CNT_EN only) completed output frames
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont_en,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  input  logic              source_valid,
  input  logic              source_sop,
  input  logic              source_eop,
  output logic [CNT_W-1:0]  bin_idx,
  output logic              frame_done,
  output logic              busy,
  output logic              ovf_err,
  output logic              frm_err
`ifdef FFT_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_PT = CNT_W'(FFT_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] load_cnt;
  logic             emptying;
  logic             eop_acc;
  logic             load_en;
  logic             ovf_hit;

  assign emptying = sink_valid & sink_ready;
  assign eop_acc  = emptying & sink_eop;

  // A sample may enter the register when it is free or draining this cycle.
  // A held eop blocks new loads until it is accepted. Even then, the next
  // frame may load in the same cycle only in continuous mode; otherwise we
  // leave LOAD.
  assign load_en = (state == LOAD) & smp_valid &
                   (~sink_valid | (sink_ready & (~sink_eop | cont_en)));

  // The register is stuck behind backpressure, so the incoming sample is lost.
  assign ovf_hit = (state == LOAD) & smp_valid & sink_valid & ~sink_ready;

  assign busy = (state != IDLE);

  // Sequencer plus sink output register. The load counter wraps on the eop
  // load, so a continuous-mode frame restarts at point 0 without extra logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      load_cnt   <= '0;
      sink_valid <= 1'b0;
      sink_sop   <= 1'b0;
      sink_eop   <= 1'b0;
      sink_real  <= '0;
      ovf_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            load_cnt <= '0;
          end
        end
        LOAD: begin
          if (eop_acc && !cont_en) begin
            state <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          if (source_valid && source_eop) begin
            state    <= start ? LOAD : IDLE;
            load_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (load_en) begin
        sink_valid <= 1'b1;
        sink_real  <= smp_data;
        sink_sop   <= (load_cnt == '0);
        sink_eop   <= (load_cnt == LAST_PT);
        load_cnt   <= (load_cnt == LAST_PT) ? '0 : load_cnt + 1'b1;
      end else if (emptying) begin
        sink_valid <= 1'b0;
        sink_sop   <= 1'b0;
        sink_eop   <= 1'b0;
      end

      if (ovf_hit) begin
        ovf_err <= 1'b1;
      end
    end
  end

  fft_bin_tracker #(
    .FFT_LEN (FFT_LEN),
    .CNT_W   (CNT_W)
  ) u_bin_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .bin_idx      (bin_idx),
    .frame_done   (frame_done),
    .frm_err      (frm_err)
`ifdef FFT_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl
// Directed bench for fft_frame_ctrl with 8-point frames. It covers burst
// capture, backpressure with sample loss, continuous framing, output bin
// tracking, framing faults and reset mid-frame.
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  localparam int FFT_LEN = 8;
  localparam int CNT_W   = 3;
  localparam int DATA_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cont_en = 1'b0;
  logic              smp_valid = 1'b0;
  logic [DATA_W-1:0] smp_data = '0;
  logic              sink_ready = 1'b1;
  logic              sink_valid, sink_sop, sink_eop;
  logic [DATA_W-1:0] sink_real;
  logic              source_valid = 1'b0;
  logic              source_sop = 1'b0;
  logic              source_eop = 1'b0;
  logic [CNT_W-1:0]  bin_idx;
  logic              frame_done, busy, ovf_err, frm_err;
`ifdef FFT_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fft_frame_ctrl #(
    .FFT_LEN (FFT_LEN),
    .CNT_W   (CNT_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cont_en      (cont_en),
    .smp_valid    (smp_valid),
    .smp_data     (smp_data),
    .sink_ready   (sink_ready),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .bin_idx      (bin_idx),
    .frame_done   (frame_done),
    .busy         (busy),
    .ovf_err      (ovf_err),
    .frm_err      (frm_err)
`ifdef FFT_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put every input back to rest and pulse reset away from the clock edge.
  task automatic do_reset();
    start = 0; cont_en = 0; smp_valid = 0; smp_data = '0; sink_ready = 1;
    source_valid = 0; source_sop = 0; source_eop = 0;
    rst_n = 0;
    step();
    step();
    #2 rst_n = 1;
    step();
  endtask

  // Everything must read zero while reset is asserted.
  task automatic test_reset();
    rst_n = 0;
    #12;
    n_cmp++;
    if ({sink_valid, sink_sop, sink_eop, sink_real, bin_idx, frame_done, busy, ovf_err, frm_err} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got v=%b sop=%b eop=%b real=%0d bin=%0d done=%b busy=%b ovf=%b frm=%b, expected all 0",
               sink_valid, sink_sop, sink_eop, sink_real, bin_idx, frame_done, busy, ovf_err, frm_err);
    end
    #5 rst_n = 1;
    step();
  endtask

  // One frame with data 1..8 and no backpressure.
  task automatic test_burst();
    int n;
    n = 0;
    start = 1; step(); start = 0;
    for (int c = 1; c <= 11; c++) begin
      smp_valid = (c <= 8);
      smp_data  = DATA_W'(c);
      if (c == 1 || c == 2) begin
        n_cmp++;
        if (sink_valid !== (c == 2)) begin
          n_bad++;
          $display("[TB] FAIL burst_latency: cycle %0d sink_valid=%b expected %b", c, sink_valid, (c == 2));
        end
      end
      if (sink_valid && sink_ready) begin
        n++;
        n_cmp++;
        if ({sink_sop, sink_eop, sink_real} !== {(n == 1), (n == 8), DATA_W'(n)}) begin
          n_bad++;
          $display("[TB] FAIL burst_point%0d: got sop=%b eop=%b real=%0d, expected sop=%b eop=%b real=%0d",
                   n, sink_sop, sink_eop, sink_real, (n == 1), (n == 8), n);
        end
      end
      step();
    end
    smp_valid = 0;
    n_cmp++;
    if (n !== 8) begin
      n_bad++;
      $display("[TB] FAIL burst_count: got %0d transfers, expected 8", n);
    end
    n_cmp++;
    if ({dut.state == WAIT_OUT, busy, ovf_err, sink_valid} !== 4'b1100) begin
      n_bad++;
      $display("[TB] FAIL burst_end: state=%0d busy=%b ovf=%b valid=%b, expected WAIT_OUT busy=1 ovf=0 valid=0",
               dut.state, busy, ovf_err, sink_valid);
    end
  endtask

  // A clean 8-bin output frame ends WAIT_OUT.
  task automatic test_output();
    for (int b = 0; b < 8; b++) begin
      source_valid = 1; source_sop = (b == 0); source_eop = (b == 7);
      #1;
      n_cmp++;
      if (bin_idx !== CNT_W'(b)) begin
        n_bad++;
        $display("[TB] FAIL output_bin: got %0d expected %0d", bin_idx, b);
      end
      step();
    end
    source_valid = 0; source_sop = 0; source_eop = 0;
    n_cmp++;
    if ({frame_done, busy, frm_err} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL output_done: got done=%b busy=%b frm=%b, expected done=1 busy=0 frm=0", frame_done, busy, frm_err);
    end
    step();
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL output_pulse: frame_done=%b one cycle later, expected 0", frame_done);
    end
`ifdef FFT_FRAME_CNT_EN
    n_cmp++;
    if (frame_cnt !== 16'd1) begin
      n_bad++;
      $display("[TB] FAIL frame_cnt: got %0d expected 1", frame_cnt);
    end
`endif
  endtask

  // The sink stalls for three cycles while point 4 is held. Samples 5..7 are
  // lost, and the frame completes with samples 8..11.
  task automatic test_backpressure();
    int n;
    int exp_data[8];
    exp_data = '{1, 2, 3, 4, 8, 9, 10, 11};
    n = 0;
    start = 1; step(); start = 0;
    for (int c = 1; c <= 14; c++) begin
      smp_valid  = (c <= 12);
      smp_data   = DATA_W'(c);
      sink_ready = !(c >= 5 && c <= 7);
      if (!sink_ready) begin
        n_cmp++;
        if ({sink_valid, sink_real} !== {1'b1, DATA_W'(4)}) begin
          n_bad++;
          $display("[TB] FAIL bp_hold: cycle %0d valid=%b real=%0d, expected valid=1 real=4", c, sink_valid, sink_real);
        end
      end
      if (sink_valid && sink_ready) begin
        n_cmp++;
        if (n < 8 && {sink_sop, sink_eop, sink_real} !== {(n == 0), (n == 7), DATA_W'(exp_data[n])}) begin
          n_bad++;
          $display("[TB] FAIL bp_point%0d: got sop=%b eop=%b real=%0d, expected sop=%b eop=%b real=%0d",
                   n + 1, sink_sop, sink_eop, sink_real, (n == 0), (n == 7), exp_data[n]);
        end
        n++;
      end
      step();
    end
    smp_valid = 0; sink_ready = 1;
    n_cmp++;
    if (n !== 8) begin
      n_bad++;
      $display("[TB] FAIL bp_count: got %0d transfers, expected 8", n);
    end
    n_cmp++;
    if ({ovf_err, dut.state == WAIT_OUT} !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL bp_end: ovf=%b state=%0d, expected ovf=1 state WAIT_OUT", ovf_err, dut.state);
    end
    do_reset();
  endtask

  // In continuous mode, 20 back-to-back samples span two full frames plus 4.
  task automatic test_continuous();
    int n;
    n = 0;
    cont_en = 1;
    start = 1; step(); start = 0;
    for (int c = 1; c <= 22; c++) begin
      smp_valid = (c <= 20);
      smp_data  = DATA_W'(c);
      if (sink_valid && sink_ready) begin
        n++;
        n_cmp++;
        if ({sink_sop, sink_eop, sink_real} !== {(n % 8 == 1), (n % 8 == 0), DATA_W'(n)}) begin
          n_bad++;
          $display("[TB] FAIL cont_point%0d: got sop=%b eop=%b real=%0d, expected sop=%b eop=%b real=%0d",
                   n, sink_sop, sink_eop, sink_real, (n % 8 == 1), (n % 8 == 0), n);
        end
      end
      step();
    end
    smp_valid = 0;
    n_cmp++;
    if ({n == 20, dut.state == LOAD, busy, dut.load_cnt} !== {3'b111, 3'd4}) begin
      n_bad++;
      $display("[TB] FAIL cont_end: transfers=%0d state=%0d busy=%b load_cnt=%0d, expected 20 LOAD 1 4",
               n, dut.state, busy, dut.load_cnt);
    end
    do_reset();
  endtask

  // An eop at bin 5 is a framing fault, and the flag must stick.
  task automatic test_framing();
    for (int b = 0; b < 6; b++) begin
      source_valid = 1; source_sop = (b == 0); source_eop = (b == 5);
      step();
    end
    source_valid = 0; source_sop = 0; source_eop = 0;
    n_cmp++;
    if (frm_err !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL frm_set: frm_err=%b expected 1", frm_err);
    end
    repeat (3) step();
    n_cmp++;
    if (frm_err !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL frm_sticky: frm_err=%b expected 1", frm_err);
    end
  endtask

  // Abandon a frame after 3 points. The next start must begin a fresh frame.
  task automatic test_reset_midframe();
    start = 1; step(); start = 0;
    for (int c = 1; c <= 3; c++) begin
      smp_valid = 1; smp_data = DATA_W'(c);
      step();
    end
    smp_valid = 0;
    n_cmp++;
    if ({sink_valid, sink_real} !== {1'b1, DATA_W'(3)}) begin
      n_bad++;
      $display("[TB] FAIL mid_pre: valid=%b real=%0d, expected valid=1 real=3", sink_valid, sink_real);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({sink_valid, sink_sop, sink_eop, sink_real, frame_done, busy, ovf_err, frm_err} !== '0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset: v=%b sop=%b eop=%b real=%0d done=%b busy=%b ovf=%b frm=%b, expected all 0",
               sink_valid, sink_sop, sink_eop, sink_real, frame_done, busy, ovf_err, frm_err);
    end
    #2 rst_n = 1;
    step();
    start = 1; step(); start = 0;
    smp_valid = 1; smp_data = DATA_W'(12'h155);
    step();
    smp_valid = 0;
    n_cmp++;
    if ({sink_valid, sink_sop, sink_eop, sink_real} !== {3'b110, DATA_W'(12'h155)}) begin
      n_bad++;
      $display("[TB] FAIL mid_fresh: v=%b sop=%b eop=%b real=%0h, expected v=1 sop=1 eop=0 real=155",
               sink_valid, sink_sop, sink_eop, sink_real);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_output();
    test_backpressure();
    test_continuous();
    test_framing();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
